// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared state encoding for the operand loader.
package operand_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_READY = 2'd2
    } loader_state_t;

endpackage

// File: rtl/operand_loader_press_detect.sv
// press_detect: one-cycle press pulse on the high-to-low edge of an active-low button.
module press_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    logic load_q;

    always_ff @(posedge clk_i) load_q <= !rst_i ? 1'b1 : btn_i;

    assign press_o = load_q & ~btn_i;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: captures N_OPERANDS values, one per button press, then holds them for the datapath.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter  int WIDTH      = 4,
    parameter  int N_OPERANDS = 2,
    localparam int IDX_W      = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic [WIDTH-1:0]            input_i,
    input  logic                        abort_i,
    input  logic                        done_i,
    output logic                        compute_o,
    output logic [N_OPERANDS*WIDTH-1:0] operands_o,
    output logic [IDX_W-1:0]            index_o,
    output logic                        busy_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OPERANDS - 1);
    localparam bit               ONE  = (N_OPERANDS == 1);

    loader_state_t    state_q;
    logic [IDX_W-1:0] index_q;
    logic [WIDTH-1:0] ops_q [N_OPERANDS];
    logic             press;

    press_detect u_press (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .btn_i  (load_i),
        .press_o(press)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= LDR_IDLE;
            index_q <= '0;
            for (int i = 0; i < N_OPERANDS; i++) ops_q[i] <= '0;
        end else begin
            case (state_q)
                LDR_IDLE: if (press) begin
                    ops_q[0] <= input_i;
                    state_q  <= ONE ? LDR_READY : LDR_LOAD;
                    index_q  <= ONE ? '0 : IDX_W'(1);
                end
                // abort outranks a same-cycle press, so nothing is captured
                LDR_LOAD: if (abort_i) begin
                    state_q <= LDR_IDLE;
                    index_q <= '0;
                end else if (press) begin
                    ops_q[index_q] <= input_i;
                    state_q        <= (index_q == LAST) ? LDR_READY : LDR_LOAD;
                    index_q        <= (index_q == LAST) ? '0 : index_q + 1'b1;
                end
                LDR_READY: if (done_i) begin
                    state_q <= LDR_IDLE;
                    index_q <= '0;
                end
                default: begin
                    state_q <= LDR_IDLE;
                    index_q <= '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_OPERANDS; k++) begin : g_flat
        assign operands_o[k*WIDTH +: WIDTH] = ops_q[k];
    end

    assign compute_o = (state_q == LDR_READY);
    assign busy_o    = (state_q == LDR_LOAD);
    assign index_o   = index_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: scoreboard bench over three parameterisations of operand_loader.
module tb_operand_loader;
    import operand_loader_pkg::*;

    typedef struct {
        int            id;
        loader_state_t st;
        logic          comp;
        logic          busy;
        int            idx;
        logic [31:0]   ops;
        string         name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ld = 3'b111;
    logic [2:0] ab = 3'b000;
    logic [2:0] dn = 3'b000;
    logic [7:0] din = 8'h00;

    logic        c0, c1, c2, b0, b1, b2;
    logic [7:0]  o0;
    logic [11:0] o1;
    logic [31:0] o2;
    logic [0:0]  i0;
    logic [1:0]  i1, i2;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    operand_loader #(.WIDTH(4), .N_OPERANDS(2)) d0 (
        .clk_i(clk), .rst_i(rst_n), .load_i(ld[0]), .input_i(din[3:0]), .abort_i(ab[0]),
        .done_i(dn[0]), .compute_o(c0), .operands_o(o0), .index_o(i0), .busy_o(b0));
    operand_loader #(.WIDTH(4), .N_OPERANDS(3)) d1 (
        .clk_i(clk), .rst_i(rst_n), .load_i(ld[1]), .input_i(din[3:0]), .abort_i(ab[1]),
        .done_i(dn[1]), .compute_o(c1), .operands_o(o1), .index_o(i1), .busy_o(b1));
    operand_loader #(.WIDTH(8), .N_OPERANDS(4)) d2 (
        .clk_i(clk), .rst_i(rst_n), .load_i(ld[2]), .input_i(din), .abort_i(ab[2]),
        .done_i(dn[2]), .compute_o(c2), .operands_o(o2), .index_o(i2), .busy_o(b2));

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t          e;
            loader_state_t ast;
            logic          ac, ab_;
            int            ai;
            logic [31:0]   ao;
            e = sb.pop_front();
            case (e.id)
                0:       begin ast = d0.state_q; ac = c0; ab_ = b0; ai = int'(i0); ao = {24'h0, o0}; end
                1:       begin ast = d1.state_q; ac = c1; ab_ = b1; ai = int'(i1); ao = {20'h0, o1}; end
                default: begin ast = d2.state_q; ac = c2; ab_ = b2; ai = int'(i2); ao = o2; end
            endcase
            total++;
            if (ast !== e.st || ac !== e.comp || ab_ !== e.busy || ai != e.idx || ao !== e.ops) begin
                bad++;
                $display("FAIL %s: got st=%0d compute=%b busy=%b index=%0d ops=%h, want st=%0d compute=%b busy=%b index=%0d ops=%h",
                         e.name, ast, ac, ab_, ai, ao, e.st, e.comp, e.busy, e.idx, e.ops);
            end
        end
    end

    task automatic step(input int id, input bit rn, input bit l, input logic [7:0] v,
                        input bit a, input bit d, input loader_state_t st, input bit c,
                        input bit b, input int ix, input logic [31:0] ops, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        ld = 3'b111; ld[id] = l;
        ab = 3'b000; ab[id] = a;
        dn = 3'b000; dn[id] = d;
        din = v;
        @(posedge clk);
        e.id = id; e.st = st; e.comp = c; e.busy = b; e.idx = ix; e.ops = ops; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        step(0, 0, 1, 8'h0, 0, 0, LDR_IDLE, 0, 0, 0, 32'h0, "rst_d0");
        step(1, 0, 1, 8'h0, 0, 0, LDR_IDLE, 0, 0, 0, 32'h0, "rst_d1");
        step(2, 1, 1, 8'h0, 0, 0, LDR_IDLE, 0, 0, 0, 32'h0, "rst_d2");

        step(0, 1, 0, 8'h3, 0, 0, LDR_LOAD,  0, 1, 1, 32'h03, "d0_cap0");
        step(0, 1, 1, 8'h3, 0, 0, LDR_LOAD,  0, 1, 1, 32'h03, "d0_rel0");
        step(0, 1, 0, 8'hA, 0, 0, LDR_READY, 1, 0, 0, 32'hA3, "d0_cap1");
        step(0, 1, 1, 8'hA, 0, 0, LDR_READY, 1, 0, 0, 32'hA3, "d0_hold");
        step(0, 1, 0, 8'hF, 0, 1, LDR_IDLE,  0, 0, 0, 32'hA3, "d0_done_press");
        step(0, 1, 1, 8'hF, 0, 0, LDR_IDLE,  0, 0, 0, 32'hA3, "d0_idle");
        step(0, 1, 0, 8'h2, 0, 0, LDR_LOAD,  0, 1, 1, 32'hA2, "d0_new_slot0");
        step(0, 1, 1, 8'h2, 0, 0, LDR_LOAD,  0, 1, 1, 32'hA2, "d0_new_rel");

        step(1, 1, 0, 8'h5, 0, 0, LDR_LOAD, 0, 1, 1, 32'h005, "d1_cap5");
        step(1, 1, 1, 8'h5, 0, 0, LDR_LOAD, 0, 1, 1, 32'h005, "d1_rel5");
        step(1, 1, 0, 8'h7, 1, 0, LDR_IDLE, 0, 0, 0, 32'h005, "d1_abort_press");
        step(1, 1, 1, 8'h7, 0, 0, LDR_IDLE, 0, 0, 0, 32'h005, "d1_after_abort");
        for (int k = 1; k <= 10; k++)
            step(1, 1, 0, 8'(k > 9 ? 9 : k), 0, 0, LDR_LOAD, 0, 1, 1, 32'h001, $sformatf("d1_held%0d", k));
        step(1, 1, 1, 8'h9, 0, 0, LDR_LOAD,  0, 1, 1, 32'h001, "d1_held_rel");
        step(1, 1, 1, 8'h9, 1, 0, LDR_IDLE,  0, 0, 0, 32'h001, "d1_abort2");
        step(1, 1, 0, 8'h1, 0, 0, LDR_LOAD,  0, 1, 1, 32'h001, "d1_s0");
        step(1, 1, 1, 8'h1, 0, 0, LDR_LOAD,  0, 1, 1, 32'h001, "d1_r0");
        step(1, 1, 0, 8'h2, 0, 0, LDR_LOAD,  0, 1, 2, 32'h021, "d1_s1");
        step(1, 1, 1, 8'h2, 0, 0, LDR_LOAD,  0, 1, 2, 32'h021, "d1_r1");
        step(1, 1, 0, 8'h3, 0, 0, LDR_READY, 1, 0, 0, 32'h321, "d1_s2_ready");
        step(1, 1, 1, 8'h3, 0, 0, LDR_READY, 1, 0, 0, 32'h321, "d1_r2");
        step(1, 1, 0, 8'h8, 1, 0, LDR_READY, 1, 0, 0, 32'h321, "d1_ready_ignores");
        step(1, 1, 0, 8'h8, 0, 1, LDR_IDLE,  0, 0, 0, 32'h321, "d1_done_held");
        step(1, 1, 0, 8'h8, 0, 0, LDR_IDLE,  0, 0, 0, 32'h321, "d1_no_retrigger");

        step(2, 1, 0, 8'h11, 0, 0, LDR_LOAD, 0, 1, 1, 32'h11,   "d2_c11");
        step(2, 1, 1, 8'h11, 0, 0, LDR_LOAD, 0, 1, 1, 32'h11,   "d2_r11");
        step(2, 1, 0, 8'h22, 0, 0, LDR_LOAD, 0, 1, 2, 32'h2211, "d2_c22");
        step(2, 0, 1, 8'h22, 0, 0, LDR_IDLE, 0, 0, 0, 32'h0,    "d2_mid_reset");
        step(2, 1, 1, 8'h22, 0, 0, LDR_IDLE, 0, 0, 0, 32'h0,    "d2_post_reset");
        step(2, 1, 0, 8'h33, 0, 0, LDR_LOAD, 0, 1, 1, 32'h33,   "d2_c33");
        step(2, 1, 1, 8'h33, 0, 0, LDR_LOAD, 0, 1, 1, 32'h33,   "d2_r33");
        step(2, 1, 0, 8'h44, 0, 0, LDR_LOAD, 0, 1, 2, 32'h4433, "d2_c44");
        step(2, 1, 1, 8'h44, 0, 0, LDR_LOAD, 0, 1, 2, 32'h4433, "d2_r44");
        step(2, 1, 0, 8'h55, 0, 0, LDR_LOAD, 0, 1, 3, 32'h554433, "d2_c55");
        step(2, 1, 1, 8'h55, 0, 0, LDR_LOAD, 0, 1, 3, 32'h554433, "d2_r55");
        step(2, 1, 0, 8'h66, 0, 0, LDR_READY, 1, 0, 0, 32'h66554433, "d2_c66_wrap");

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
# operand_loader

Parametrised operand capture controller that sits between the board's debounced push-button/switch inputs and the arithmetic datapath. It collects `N_OPERANDS` values of `WIDTH` bits from a shared input bus, one per button press, and then raises `compute_o`. The captured operands stay stable until the datapath acknowledges completion, after which a new load sequence can start. Each press is edge-detected, so holding the button captures exactly one operand. `abort_i` cancels a partial load.

## Interface
Parameters:
- `WIDTH`, 4, operand width in bits (≥1)
- `N_OPERANDS`, 2, number of operands per sequence (≥1)
- `IDX_W`, max(1, $clog2(N_OPERANDS)), width of the slot index (derived, not overridden)

Ports (one clock; reset is synchronous and active-low):
- `clk_i`  in  1  clock, all state changes on rising edge
- `rst_i`  in  1  synchronous active-low reset
- `load_i`  in  1  active-low load button, already synchronised and debounced upstream
- `input_i`  in  WIDTH  operand value to capture
- `abort_i`  in  1  active-high; cancels a load in progress
- `done_i`  in  1  active-high; datapath acknowledges the result
- `compute_o`  out  1  high while the full operand set is valid
- `operands_o`  out  N_OPERANDS*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
- `index_o`  out  IDX_W  slot index the next press will write
- `busy_o`  out  1  high in LDR_LOAD (partial set held)

## Operation
- Press detection: `load_q` is a register of the previous `load_i`. A press is `load_q & ~load_i`, meaning a high-to-low transition. Holding `load_i` low yields one press.
- States (from the package enum): LDR_IDLE, LDR_LOAD, LDR_READY.
- LDR_IDLE:
  - On a press, write `input_i` into slot 0 and set `index_o` to 1.
  - Go to LDR_READY if N_OPERANDS==1, otherwise go to LDR_LOAD.
  - `abort_i` and `done_i` are ignored.
- LDR_LOAD:
  - On a press, write `input_i` into slot `index_o`.
  - If `index_o`==N_OPERANDS-1, go to LDR_READY. Otherwise increment `index_o`.
  - `abort_i` returns to LDR_IDLE with `index_o`=0. Slots already written keep their values.
- LDR_READY:
  - `compute_o`=1 and `operands_o` is frozen. Presses and `abort_i` are ignored.
  - `done_i` returns to LDR_IDLE with `index_o`=0. Operands are retained until overwritten by the next sequence.
- On entry to LDR_READY, `index_o` holds 0 (wrap-around). Slot writes use the index value before the update.
- Only the addressed slot changes on a capture. All other slots hold.

## Timing
- Reset values (rst_i low at a rising edge):
  - `compute_o`=0, `busy_o`=0, `index_o`=0, `operands_o`=0
  - state=LDR_IDLE, `load_q`=1
  - Reset takes priority over every other input in any state, including mid-sequence.
- Capture latency: if `load_i` is sampled low at edge k and `load_q` was 1, the slot updates at edge k and is visible on `operands_o` right after edge k.
- `compute_o` rises at the same edge as the final capture. It falls at the edge where `done_i` is sampled high in LDR_READY.
- Outputs are all registered or decoded directly from registered state. There are no combinational paths from inputs to outputs.
- Simultaneous events:
  - `abort_i` together with a press in LDR_LOAD: abort wins and nothing is captured.
  - `done_i` together with a press in LDR_READY: only done acts. The press is consumed, not captured.
- A press that is still held across the return to LDR_IDLE does not re-trigger. A new high-to-low edge is required.

## Structure
- `operand_loader_pkg`: the `loader_state_t` enum (LDR_IDLE, LDR_LOAD, LDR_READY), sized to 2 bits. The package is imported by the block and by the bench.
- Sub-module `press_detect`: owns the `load_q` register with reset value 1. It outputs a one-cycle `press` pulse and is reused for the other buttons on the board.
- Operand storage is a WIDTH × N_OPERANDS register array, flattened onto `operands_o`.

## Test plan
- Reset then idle: `rst_i`=0 for 2 cycles with `load_i`=1 → all outputs are 0 and the state is LDR_IDLE.
- Default params: press with `input_i`=4'h3, then press with 4'hA → `operands_o`=8'hA3, `compute_o`=1 from the second capture edge, `index_o`=0.
- Held button: `load_i` low for 10 cycles with `input_i` changing 1..9 → only slot 0 is written (value 1), `index_o`=1, `busy_o`=1.
- Abort: N_OPERANDS=3. Capture 5, press plus `abort_i` in the same cycle with 7 → state LDR_IDLE, `index_o`=0, slot 0=5, slot 1=0.
- Done handshake: in LDR_READY, apply `done_i` together with a press of 4'hF → `compute_o` falls next edge, operands unchanged. A new press of 4'h2 then writes slot 0 only.
- Mid-sequence reset: WIDTH=8, N_OPERANDS=4. After 2 captures (8'h11, 8'h22), assert `rst_i`=0 for one cycle → `operands_o`=0, `index_o`=0, and the next press writes slot 0.
